// File: rtl/fetch_queue.sv
// Instruction-fetch front end: DEPTH-entry {pc, instr} prefetch FIFO fed by
// sequential word fetches, drained by a valid/ready decoder port, with redirect/flush.
module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       decoder_ready,
  output logic                       fetcher_valid,
  output logic [XLEN-1:0]            instr,
  output logic [XLEN-1:0]            fetcher_pc,
  output logic [$clog2(DEPTH+1)-1:0] fetch_count,
  input  logic                       mem_valid,
  input  logic [XLEN-1:0]            mem_rdata,
  output logic                       mem_ready,
  output logic                       mem_instr,
  output logic [XLEN-1:0]            mem_addr,
  output logic [3:0]                 mem_wstrb
);
  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = $clog2(DEPTH+1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [0:0]      S_IDLE = 1'b0;
  localparam logic [0:0]      S_REQ  = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          fifo [DEPTH];
  logic [0:0]      state;
  logic [XLEN-1:0] fetch_pc;
  logic            discard;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count_after_pop;
  logic [XLEN-1:0] redirect_target;
  logic            pop, resp, push, issue;
  logic            unused;

  assign unused          = ^redirect_pc[1:0];
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  assign fetcher_valid   = (fetch_count != '0) && !redirect_valid;
  assign pop             = fetcher_valid && decoder_ready;
  assign resp            = (state == S_REQ) && mem_valid;
  // A response is kept only if it belongs to the current stream.
  assign push            = resp && !discard && !redirect_valid;
  assign count_after_pop = fetch_count - CW'(pop);
  assign issue           = (state == S_IDLE) && !redirect_valid && (count_after_pop < FULL);

  assign instr      = fifo[rd_ptr].instr;
  assign fetcher_pc = fifo[rd_ptr].pc;
  assign mem_ready  = (state == S_REQ);
  assign mem_instr  = (state == S_REQ);
  assign mem_wstrb  = 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (issue) begin
          state    <= S_REQ;
          mem_addr <= fetch_pc;
        end
        S_REQ:  if (mem_valid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // The outstanding request is never aborted; its answer is dropped instead.
      if (resp)
        discard <= 1'b0;
      else if (redirect_valid && state == S_REQ)
        discard <= 1'b1;
      if (redirect_valid)
        fetch_pc <= redirect_target;
      else if (push)
        fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fetch_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fetch_count <= fetch_count + 1'b1;
        2'b01:   fetch_count <= fetch_count - 1'b1;
        default: fetch_count <= fetch_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{pc: fetch_pc, instr: mem_rdata};
  end

`ifdef FORMAL
  always_comb begin
    assert (mem_wstrb == 4'b0000);
    assert (fetch_count <= FULL);
    if (fetcher_valid) assert (fetch_count != '0);
  end
  addr_stable: assert property (@(posedge clk) disable iff (reset)
    (mem_ready && !mem_valid) |=> $stable(mem_addr));
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the single-entry fetcher.
- Keeps a DEPTH-entry prefetch FIFO of {pc, instr} pairs, filled by sequential word fetches over the native memory handshake.
- Drains to the decoder with a valid/ready handshake.
- Adds a redirect/flush port for branches and traps, and drops any in-flight response that belongs to a stale stream.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- XLEN, 32, width of pc, address and instruction.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] are ignored and treated as 0.
- decoder_ready  in  1  decoder accepts the head entry this cycle.
- fetcher_valid  out  1  head entry is valid.
- instr  out  XLEN  head instruction.
- fetcher_pc  out  XLEN  pc of the head instruction.
- fetch_count  out  $clog2(DEPTH+1)  current number of FIFO entries.
- mem_valid  in  1  memory response strobe; mem_rdata is valid this cycle.
- mem_rdata  in  XLEN  response data.
- mem_ready  out  1  request strobe; held high until mem_valid is sampled.
- mem_instr  out  1  1 during every request.
- mem_addr  out  XLEN  request address; stable while mem_ready is high.
- mem_wstrb  out  4  always 4'b0000.

Behaviour:
- Reset (asynchronous):
  - fetch pc <= RESET_PC; FIFO emptied; fetch_count = 0; fetcher_valid = 0.
  - mem_ready = 0, mem_instr = 0, mem_addr = 0, mem_wstrb = 0; discard flag = 0; state IDLE.
  - Deasserting reset mid-request abandons that request; the memory is also reset.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: mem_ready = 1, mem_instr = 1, mem_addr = fetch pc.
- Transitions:
  - IDLE -> REQ when fetch_count < DEPTH (counted after this cycle's pop) and redirect_valid = 0.
  - REQ -> IDLE on the cycle mem_valid = 1. The next request can issue the following cycle, so peak rate is one word per 2 cycles.
- Response handling (mem_valid in REQ):
  - Normal case (discard = 0, no redirect this cycle): push {fetch pc, mem_rdata}, then fetch pc += 4 (wraps modulo 2^XLEN).
  - If discard = 1: drop the data, clear discard, and leave fetch pc unchanged (it already holds the redirect target).
- A request is only issued when there is a free slot. With one outstanding request, a push can therefore never overflow.
- Output side:
  - instr and fetcher_pc come combinationally from the FIFO head.
  - fetcher_valid = (fetch_count != 0) && !redirect_valid.
  - A pop occurs when fetcher_valid && decoder_ready.
  - A push and a pop in the same cycle leave fetch_count unchanged.
  - Latency: mem_valid on cycle N gives fetcher_valid = 1 on cycle N+1 when the queue was empty.
- Redirect (priority over everything else):
  - FIFO is flushed at the edge; fetch_count = 0 next cycle.
  - fetch pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - A pop in the redirect cycle is ignored.
  - In IDLE: the next cycle enters REQ at the new pc.
  - In REQ without mem_valid: mem_ready stays high and mem_addr stays unchanged (no abort); discard is set.
  - In REQ with mem_valid in the same cycle: the response is dropped and discard stays 0.
  - Redirect while discard = 1: pc is updated and discard stays set.
  - Back-to-back redirects: the last one wins.
- Pointers: rd/wr pointers are $clog2(DEPTH) bits and wrap naturally. Full means fetch_count == DEPTH.
- Formal properties (under FORMAL):
  - mem_wstrb == 0 at all times.
  - mem_addr is stable while mem_ready && !mem_valid.
  - fetch_count <= DEPTH.
  - fetcher_valid implies fetch_count != 0.

Test Plan:
- Reset, memory answers every request 1 cycle after mem_ready, decoder_ready = 1 -> mem_addr sequence 0x0, 0x4, 0x8; decoder receives those pcs in order with the matching mem_rdata.
- decoder_ready = 0, DEPTH = 4 -> exactly 4 requests (0x0 to 0xC); mem_ready stays 0 while fetch_count = 4. Raise decoder_ready for 1 cycle -> one pop, then one new request at 0x10.
- Redirect to 0x103 while in IDLE with 3 entries queued -> fetcher_valid = 0 next cycle, fetch_count = 0, next mem_addr = 0x100.
- Redirect to 0x200 while a request to 0x8 is outstanding, response arrives 3 cycles later -> that response is not pushed, next mem_addr = 0x200, first decoded pc = 0x200.
- Redirect in the same cycle as mem_valid with decoder_ready = 1 and the queue non-empty -> no push, no pop takes effect, fetch_count = 0, next request at the redirect pc.
- Assert reset asynchronously between clock edges mid-REQ -> mem_ready and fetcher_valid go 0 before the next edge; the first request after release is at RESET_PC.
